// File: rtl/nfc_op_seq_pkg.sv
// Shared definitions for the NAND operation sequencer slice.
// Holds default widths, operation type codes, the ONFI default command bytes
// and the sequencer state encoding used by nfc_op_seq and its interface.
package nfc_op_seq_pkg;

  localparam int SFR_WID_DEF = 8;   // command byte width
  localparam int DAT_WID     = 14;  // data byte/word count width
  localparam int ADDR_WID    = 32;  // column / row address width
  localparam int ACNT_WID    = 6;   // packed column/row address cycle counts

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_PROG  = 2'd1,
    OP_ERASE = 2'd2,
    OP_STAT  = 2'd3
  } op_type_e;

  // Default command bytes; software normally programs these into op_cmd1/2.
  localparam logic [7:0] CMD_READ1  = 8'h00;
  localparam logic [7:0] CMD_READ2  = 8'h30;
  localparam logic [7:0] CMD_PROG1  = 8'h80;
  localparam logic [7:0] CMD_PROG2  = 8'h10;
  localparam logic [7:0] CMD_ERASE1 = 8'h60;
  localparam logic [7:0] CMD_ERASE2 = 8'hD0;
  localparam logic [7:0] CMD_STATUS = 8'h70;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CMD1    = 4'd1,
    ST_ADDR    = 4'd2,
    ST_WDAT    = 4'd3,
    ST_CMD2    = 4'd4,
    ST_TWB     = 4'd5,
    ST_WAIT_RB = 4'd6,
    ST_RDAT    = 4'd7,
    ST_DONE    = 4'd8
  } state_e;

endpackage

// File: rtl/nfc_op_seq_if.sv
// Phase strobe bus between the operation sequencer and nfc_if.
// master: sequencer drives cmd/addr/data phase strobes and latched operands,
//         receives the per-phase done pulses. slave: the nfc_if side.
interface nfc_op_seq_if
  import nfc_op_seq_pkg::*;
#(
  parameter int SFR_WID = SFR_WID_DEF
);

  logic                nfc_cmd_en;
  logic [SFR_WID-1:0]  nfc_if_cmd;
  logic                nfc_addr_en;
  logic [ADDR_WID-1:0] nfc_col_addr;
  logic [ADDR_WID-1:0] nfc_row_addr;
  logic [ACNT_WID-1:0] nfc_addr_cnt;
  logic                nfc_dat_en;
  logic                nfc_dat_dir;
  logic [DAT_WID-1:0]  nfc_dat_cnt;
  logic                nfif_cmd_done;
  logic                nfif_addr_done;
  logic                nfif_dat_done;

  modport master (
    output nfc_cmd_en, nfc_if_cmd, nfc_addr_en, nfc_col_addr, nfc_row_addr,
           nfc_addr_cnt, nfc_dat_en, nfc_dat_dir, nfc_dat_cnt,
    input  nfif_cmd_done, nfif_addr_done, nfif_dat_done
  );

  modport slave (
    input  nfc_cmd_en, nfc_if_cmd, nfc_addr_en, nfc_col_addr, nfc_row_addr,
           nfc_addr_cnt, nfc_dat_en, nfc_dat_dir, nfc_dat_cnt,
    output nfif_cmd_done, nfif_addr_done, nfif_dat_done
  );

endinterface

// File: rtl/nfc_op_seq_rb_sync.sv
// Ready/busy synchroniser plus shared tWB / busy-timeout counter.
// Latency: nf_rb reaches rb_ok after 2 clk; counter outputs are combinational.
// Backpressure: none; the counter simply follows the in_twb/in_wait phase.
// Ports: nf_rb (async pin), cnt_clr (phase change), in_twb/in_wait (phase),
//        twb_end (tWB elapsed), rb_ok (ready seen while waiting), rb_to (timeout).
module nfc_op_seq_rb_sync #(
  parameter int TWB_CYC = 8,
  parameter int TO_WID  = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic nf_rb,
  input  logic cnt_clr,
  input  logic in_twb,
  input  logic in_wait,
  output logic twb_end,
  output logic rb_ok,
  output logic rb_to
);

  logic              rb_m;
  logic              rb_s;
  logic [TO_WID-1:0] cnt_q;

  // cnt_q holds the number of cycles spent in the current phase, counting the
  // present one: it loads 1 on the phase-change edge. This makes twb_end and
  // rb_to fall exactly TWB_CYC and 2^TO_WID-1 cycles after phase entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_m  <= 1'b1;
      rb_s  <= 1'b1;
      cnt_q <= '0;
    end else begin
      rb_m <= nf_rb;
      rb_s <= rb_m;
      if (cnt_clr) begin
        cnt_q <= TO_WID'(1);
      end else if ((in_twb || in_wait) && !(&cnt_q)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign twb_end = in_twb && (cnt_q == TO_WID'(TWB_CYC));
  assign rb_ok   = in_wait && rb_s;
  assign rb_to   = in_wait && (&cnt_q);

endmodule

// File: rtl/nfc_op_seq.sv
// Sequences one page read/program, block erase or status op into nfc_if phases.
// Latency: cmd strobe 1 clk after op_start; each phase advances on its done pulse.
// Backpressure: op_start ignored unless IDLE; phases wait on nfif_*_done / rb.
// Ports: op_* request from SFR block, nf_rb flash ready/busy pin, nfc (master
//        modport) phase strobes to nfc_if, op_busy/op_done/op_err status.
module nfc_op_seq
  import nfc_op_seq_pkg::*;
#(
  parameter int SFR_WID = SFR_WID_DEF,
  parameter int TWB_CYC = 8,
  parameter int TO_WID  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_start,
  input  logic [1:0]          op_type,
  input  logic [SFR_WID-1:0]  op_cmd1,
  input  logic [SFR_WID-1:0]  op_cmd2,
  input  logic [ADDR_WID-1:0] op_col_addr,
  input  logic [ADDR_WID-1:0] op_row_addr,
  input  logic [ACNT_WID-1:0] op_addr_cnt,
  input  logic [DAT_WID-1:0]  op_dat_cnt,
  input  logic                nf_rb,
  nfc_op_seq_if.master        nfc,
  output logic                op_busy,
  output logic                op_done,
  output logic                op_err
);

  state_e              state_q, state_d;
  op_type_e            type_q, type_d;
  logic [SFR_WID-1:0]  cmd_q, cmd_d, cmd2_q, cmd2_d;
  logic [ADDR_WID-1:0] col_q, col_d, row_q, row_d;
  logic [ACNT_WID-1:0] acnt_q, acnt_d;
  logic [DAT_WID-1:0]  dcnt_q, dcnt_d;
  logic cmd_en_q, cmd_en_d, addr_en_q, addr_en_d, dat_en_q, dat_en_d;
  logic dir_q, dir_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic twb_end, rb_ok, rb_to;

  nfc_op_seq_rb_sync #(
    .TWB_CYC (TWB_CYC),
    .TO_WID  (TO_WID)
  ) u_rb_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .nf_rb   (nf_rb),
    .cnt_clr (state_d != state_q),
    .in_twb  (state_q == ST_TWB),
    .in_wait (state_q == ST_WAIT_RB),
    .twb_end (twb_end),
    .rb_ok   (rb_ok),
    .rb_to   (rb_to)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      type_q    <= OP_READ;
      cmd_q     <= '0;
      cmd2_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      acnt_q    <= '0;
      dcnt_q    <= '0;
      cmd_en_q  <= 1'b0;
      addr_en_q <= 1'b0;
      dat_en_q  <= 1'b0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      cmd_q     <= cmd_d;
      cmd2_q    <= cmd2_d;
      col_q     <= col_d;
      row_q     <= row_d;
      acnt_q    <= acnt_d;
      dcnt_q    <= dcnt_d;
      cmd_en_q  <= cmd_en_d;
      addr_en_q <= addr_en_d;
      dat_en_q  <= dat_en_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Strobes are registered: each is raised on the edge that enters its state,
  // so cmd/addr strobes last exactly one cycle and dat_en spans the phase.
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    cmd_d     = cmd_q;
    cmd2_d    = cmd2_q;
    col_d     = col_q;
    row_d     = row_q;
    acnt_d    = acnt_q;
    dcnt_d    = dcnt_q;
    cmd_en_d  = 1'b0;
    addr_en_d = 1'b0;
    dat_en_d  = dat_en_q;
    dir_d     = dir_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: if (op_start) begin
        type_d   = op_type_e'(op_type);
        cmd_d    = op_cmd1;
        cmd2_d   = op_cmd2;
        col_d    = op_col_addr;
        row_d    = op_row_addr;
        acnt_d   = op_addr_cnt;
        dcnt_d   = op_dat_cnt;
        cmd_en_d = 1'b1;
        busy_d   = 1'b1;
        err_d    = 1'b0;
        state_d  = ST_CMD1;
      end
      ST_CMD1: if (nfc.nfif_cmd_done) begin
        if (type_q == OP_STAT) begin
          dat_en_d = 1'b1;
          dir_d    = 1'b0;
          state_d  = ST_RDAT;
        end else begin
          addr_en_d = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: if (nfc.nfif_addr_done) begin
        if (type_q == OP_PROG) begin
          dat_en_d = 1'b1;
          dir_d    = 1'b1;
          state_d  = ST_WDAT;
        end else begin
          cmd_d    = cmd2_q;
          cmd_en_d = 1'b1;
          state_d  = ST_CMD2;
        end
      end
      ST_WDAT: if (nfc.nfif_dat_done) begin
        dat_en_d = 1'b0;
        cmd_d    = cmd2_q;
        cmd_en_d = 1'b1;
        state_d  = ST_CMD2;
      end
      ST_CMD2: if (nfc.nfif_cmd_done) state_d = ST_TWB;
      ST_TWB:  if (twb_end) state_d = ST_WAIT_RB;
      ST_WAIT_RB: begin
        // Ready wins over a timeout landing in the same cycle.
        if (rb_ok) begin
          if (type_q == OP_READ) begin
            dat_en_d = 1'b1;
            dir_d    = 1'b0;
            state_d  = ST_RDAT;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (rb_to) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RDAT: if (nfc.nfif_dat_done) begin
        dat_en_d = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign nfc.nfc_cmd_en   = cmd_en_q;
  assign nfc.nfc_if_cmd   = cmd_q;
  assign nfc.nfc_addr_en  = addr_en_q;
  assign nfc.nfc_col_addr = col_q;
  assign nfc.nfc_row_addr = row_q;
  assign nfc.nfc_addr_cnt = acnt_q;
  assign nfc.nfc_dat_en   = dat_en_q;
  assign nfc.nfc_dat_dir  = dir_q;
  assign nfc.nfc_dat_cnt  = dcnt_q;
  assign op_busy          = busy_q;
  assign op_done          = done_q;
  assign op_err           = err_q;

endmodule

// File: tb/tb_nfc_op_seq.sv
// Bench for nfc_op_seq: a table of operations is replayed through a small
// nfc_if responder, followed by hand-written reset-abort and restart sequences.
module tb_nfc_op_seq;

  localparam int TWB   = 8;
  localparam int TOW   = 6;    // timeout = 63 cycles
  localparam int STUCK = 999;  // rb_low value meaning "rb never returns high"

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_start = 1'b0;
  logic [1:0]  op_type = '0;
  logic [7:0]  op_cmd1 = '0, op_cmd2 = '0;
  logic [31:0] op_col_addr = '0, op_row_addr = '0;
  logic [5:0]  op_addr_cnt = '0;
  logic [13:0] op_dat_cnt = '0;
  logic        nf_rb = 1'b1;
  logic        op_busy, op_done, op_err;

  int n_chk  = 0;
  int n_pass = 0;

  nfc_op_seq_if #(.SFR_WID(8)) nfc ();

  nfc_op_seq #(.SFR_WID(8), .TWB_CYC(TWB), .TO_WID(TOW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_start    (op_start),
    .op_type     (op_type),
    .op_cmd1     (op_cmd1),
    .op_cmd2     (op_cmd2),
    .op_col_addr (op_col_addr),
    .op_row_addr (op_row_addr),
    .op_addr_cnt (op_addr_cnt),
    .op_dat_cnt  (op_dat_cnt),
    .nf_rb       (nf_rb),
    .nfc         (nfc.master),
    .op_busy     (op_busy),
    .op_done     (op_done),
    .op_err      (op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [7:0]  c1, c2;
    logic [31:0] col, row;
    logic [5:0]  acnt;
    logic [13:0] dcnt;
    int          rb_low;  // cycles rb held low after CMD2 done (0 = stays high)
    int          lat;     // expected edges from CMD2-done edge to data/done
    logic        err;
    logic        inj;     // pulse op_start during ADDR and DONE
  } vec_t;

  vec_t vt [7];

  function automatic vec_t mk(input logic [1:0] typ, input logic [7:0] c1, c2,
                              input logic [31:0] col, row, input logic [5:0] acnt,
                              input logic [13:0] dcnt, input int rb_low, lat,
                              input logic err, inj);
    vec_t v;
    v.typ = typ; v.c1 = c1; v.c2 = c2; v.col = col; v.row = row;
    v.acnt = acnt; v.dcnt = dcnt; v.rb_low = rb_low; v.lat = lat;
    v.err = err; v.inj = inj;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // which: 0 cmd_done, 1 addr_done, 2 dat_done; returns one edge later (+1)
  task automatic pulse(input int which);
    case (which)
      0: nfc.nfif_cmd_done = 1'b1;
      1: nfc.nfif_addr_done = 1'b1;
      default: nfc.nfif_dat_done = 1'b1;
    endcase
    tick();
    nfc.nfif_cmd_done = 1'b0;
    nfc.nfif_addr_done = 1'b0;
    nfc.nfif_dat_done = 1'b0;
  endtask

  task automatic start_op(input vec_t v);
    op_type = v.typ; op_cmd1 = v.c1; op_cmd2 = v.c2;
    op_col_addr = v.col; op_row_addr = v.row;
    op_addr_cnt = v.acnt; op_dat_cnt = v.dcnt;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    // Scramble request inputs so later checks prove the operands were latched.
    op_cmd1 = 8'hFF; op_cmd2 = 8'hEE;
    op_col_addr = ~v.col; op_row_addr = ~v.row;
    op_addr_cnt = ~v.acnt; op_dat_cnt = ~v.dcnt;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int  n;
    bit  is_stat, is_prog, has_rdat;
    is_stat  = (v.typ == 2'd3);
    is_prog  = (v.typ == 2'd1);
    has_rdat = (v.typ == 2'd0) || is_stat;
    $display("vector %0d: op_type %0d cmd1 %02h", id, v.typ, v.c1);
    start_op(v);
    chk("cmd1_en",   nfc.nfc_cmd_en, 1);
    chk("cmd1_byte", nfc.nfc_if_cmd, v.c1);
    chk("busy_set",  op_busy, 1);
    chk("err_clr",   op_err, 0);
    chk("col_lat",   nfc.nfc_col_addr, v.col);
    chk("row_lat",   nfc.nfc_row_addr, v.row);
    chk("acnt_lat",  nfc.nfc_addr_cnt, v.acnt);
    chk("dcnt_lat",  nfc.nfc_dat_cnt, v.dcnt);
    tick();
    chk("cmd1_one_cycle", nfc.nfc_cmd_en, 0);
    pulse(0);
    if (!is_stat) begin
      chk("addr_en", nfc.nfc_addr_en, 1);
      if (v.inj) op_start = 1'b1;
      tick();
      op_start = 1'b0;
      chk("addr_one_cycle", nfc.nfc_addr_en, 0);
      chk("addr_cmd_quiet", nfc.nfc_cmd_en, 0);
      chk("col_hold",       nfc.nfc_col_addr, v.col);
      pulse(1);
      if (is_prog) begin
        chk("wdat_en",  nfc.nfc_dat_en, 1);
        chk("wdat_dir", nfc.nfc_dat_dir, 1);
        repeat (3) tick();
        chk("wdat_held", nfc.nfc_dat_en, 1);
        pulse(2);
        chk("wdat_clr", nfc.nfc_dat_en, 0);
      end
      chk("cmd2_en",   nfc.nfc_cmd_en, 1);
      chk("cmd2_byte", nfc.nfc_if_cmd, v.c2);
      tick();
      chk("cmd2_one_cycle", nfc.nfc_cmd_en, 0);
      nf_rb = (v.rb_low == 0);
      pulse(0);
      n = 0;
      while (!(nfc.nfc_dat_en || op_done) && n < 300) begin
        tick();
        n++;
        if (v.rb_low != STUCK && n >= v.rb_low) nf_rb = 1'b1;
      end
      chk("rb_wait_cycles", n, v.lat);
    end else begin
      chk("stat_no_addr", nfc.nfc_addr_en, 0);
    end
    if (has_rdat) begin
      chk("rdat_en",  nfc.nfc_dat_en, 1);
      chk("rdat_dir", nfc.nfc_dat_dir, 0);
      tick();
      tick();
      chk("rdat_held", nfc.nfc_dat_en, 1);
      pulse(2);
      chk("rdat_clr", nfc.nfc_dat_en, 0);
    end
    chk("done_pulse", op_done, 1);
    chk("busy_in_done", op_busy, 1);
    chk("err_at_done", op_err, v.err);
    if (v.inj) op_start = 1'b1;
    tick();
    op_start = 1'b0;
    chk("done_one_cycle", op_done, 0);
    chk("busy_clr", op_busy, 0);
    chk("err_held", op_err, v.err);
    chk("if_cmd_hold", nfc.nfc_if_cmd, is_stat ? v.c1 : v.c2);
    repeat (3) tick();
    chk("no_queued_op", op_busy, 0);
    nf_rb = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    nfc.nfif_cmd_done = 1'b0;
    nfc.nfif_addr_done = 1'b0;
    nfc.nfif_dat_done = 1'b0;

    //          typ    c1     c2     col           row           acnt       dcnt     rb    lat err inj
    vt[0] = mk(2'd3, 8'h70, 8'h00, 32'h0,        32'h0,        6'd0,      14'd1,   0,     0,  0, 0);
    vt[1] = mk(2'd0, 8'h00, 8'h30, 32'h0000_0302, 32'h0000_00AA, 6'b011_010, 14'd16, 50,    53, 0, 0);
    vt[2] = mk(2'd1, 8'h80, 8'h10, 32'h0000_0040, 32'h0000_1234, 6'b011_010, 14'h10, 20,    23, 0, 0);
    vt[3] = mk(2'd2, 8'h60, 8'hD0, 32'h0,        32'h0000_0080, 6'b011_000, 14'd0,   STUCK, 71, 1, 0);
    vt[4] = mk(2'd2, 8'h60, 8'hD0, 32'h0,        32'h0000_00C0, 6'b011_000, 14'd0,   0,     9,  0, 0);
    vt[5] = mk(2'd0, 8'h00, 8'h30, 32'h0000_0010, 32'h0000_0011, 6'b011_010, 14'd0,  10,    13, 0, 0);
    vt[6] = mk(2'd0, 8'h00, 8'h30, 32'h0000_0555, 32'h0001_0000, 6'b011_010, 14'd8,  12,    15, 0, 1);

    // Reset state
    repeat (3) tick();
    chk("rst_busy",   op_busy, 0);
    chk("rst_done",   op_done, 0);
    chk("rst_err",    op_err, 0);
    chk("rst_cmd_en", nfc.nfc_cmd_en, 0);
    chk("rst_dat_en", nfc.nfc_dat_en, 0);
    chk("rst_if_cmd", nfc.nfc_if_cmd, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // A done pulse while idle must not start or advance anything.
    pulse(0);
    chk("idle_stray_done", op_busy, 0);

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Reset asserted in the middle of a program data phase.
    start_op(vt[2]);
    pulse(0);
    pulse(1);
    chk("abort_in_wdat", nfc.nfc_dat_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",    op_busy, 0);
    chk("abort_dat_en",  nfc.nfc_dat_en, 0);
    chk("abort_dat_dir", nfc.nfc_dat_dir, 0);
    chk("abort_row",     nfc.nfc_row_addr, 0);
    chk("abort_if_cmd",  nfc.nfc_if_cmd, 0);
    chk("abort_dat_cnt", nfc.nfc_dat_cnt, 0);
    tick();
    chk("abort_no_done", op_done, 0);
    rst_n = 1'b1;
    tick();
    run_vec(7, vt[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
